// File: rtl/conv_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_row_sequencer
// Purpose  : Streams one IFM map into the 3x3 PE array row by row, then runs
//            one drain row, decoding the array/psum-FIFO strobes per (r,c).
//            Optional macro CONV_SEQ_WGT_ONCE_EN: load weights on first pixel only.
// Revision : 1.0  initial release
// ============================================================================
module conv_row_sequencer #(
    parameter int IFM_WIDTH   = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IFM_W       = 9,
    parameter int IFM_H       = 5,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [IFM_WIDTH-1:0] ifm_in,
    input  logic                 ifm_in_valid,
    output logic                 ifm_in_ready,
    output logic [IFM_WIDTH-1:0] ifm,
    output logic                 set_ifm,
    output logic                 set_wgt,
    output logic                 set_reg,
    output logic                 wr_en_0,
    output logic                 wr_en_1,
    output logic                 wr_en_2,
    output logic                 rd_en_0,
    output logic                 rd_en_1,
    output logic                 rd_en_2,
    output logic                 wr_clr,
    output logic                 rd_clr
);

    localparam int                   K      = KERNEL_SIZE;
    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(IFM_W - 1);
    localparam logic [CNT_WIDTH-1:0] C_W    = CNT_WIDTH'(IFM_W);
    localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_GAP    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] r_q, r_d, c_q, c_d;
    logic [IFM_WIDTH-1:0] ifm_q, ifm_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 set_ifm_q, set_ifm_d, set_wgt_q, set_wgt_d;
    logic [2:0]           wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic                 wr_clr_q, wr_clr_d, rd_clr_q, rd_clr_d;
    logic                 xfer, ev;
    int                   ri, ci;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        ifm_d   = ifm_q;
        ev      = 1'b0;
        xfer    = (state_q == ST_STREAM) && ifm_in_valid;
        ri      = int'(r_q);
        ci      = int'(c_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    ev    = 1'b1;
                    ifm_d = ifm_in;
                    if (c_q == C_LAST) begin
                        c_d     = C_W;
                        state_d = ST_GAP;
                    end else begin
                        c_d = c_q + C_ONE;
                    end
                end
            end
            ST_GAP: begin
                // Leaving the last IFM row lands r at IFM_H, which is the drain row.
                ev  = 1'b1;
                c_d = '0;
                r_d = r_q + C_ONE;
                state_d = (ri + 1 < IFM_H) ? ST_STREAM : ST_DRAIN;
            end
            ST_DRAIN: begin
                ev = 1'b1;
                if (c_q == C_W) begin
                    c_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    c_d = c_q + C_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        set_ifm_d = xfer;
`ifdef CONV_SEQ_WGT_ONCE_EN
        set_wgt_d = xfer && (r_q == '0) && (c_q == '0);
`else
        set_wgt_d = xfer;
`endif
        busy_d = (state_q == ST_STREAM) || (state_q == ST_GAP) || (state_q == ST_DRAIN);
        done_d = (state_q == ST_DONE);

        for (int k = 0; k < 3; k++) begin
            wr_en_d[k] = ev && (ci >= K) && (ci <= IFM_W)
                            && (ri >= k) && (ri <= k + IFM_H - K);
            rd_en_d[k] = ev && (ci <= IFM_W - K)
                            && (ri >= k + 1) && (ri <= k + 1 + IFM_H - K);
        end
        wr_clr_d = ev && (ci == 0) && (ri >= 1);
        rd_clr_d = ev && (ci == IFM_W - K + 1) && (ri >= 1);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            ifm_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            set_ifm_q <= 1'b0;
            set_wgt_q <= 1'b0;
            wr_en_q   <= '0;
            rd_en_q   <= '0;
            wr_clr_q  <= 1'b0;
            rd_clr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            c_q       <= c_d;
            ifm_q     <= ifm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            set_ifm_q <= set_ifm_d;
            set_wgt_q <= set_wgt_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_clr_q  <= wr_clr_d;
            rd_clr_q  <= rd_clr_d;
        end
    end

    assign ifm_in_ready = (state_q == ST_STREAM);
    assign busy         = busy_q;
    assign done         = done_q;
    assign ifm          = ifm_q;
    assign set_ifm      = set_ifm_q;
    assign set_wgt      = set_wgt_q;
    assign set_reg      = busy_q;
    assign wr_en_0      = wr_en_q[0];
    assign wr_en_1      = wr_en_q[1];
    assign wr_en_2      = wr_en_q[2];
    assign rd_en_0      = rd_en_q[0];
    assign rd_en_1      = rd_en_q[1];
    assign rd_en_2      = rd_en_q[2];
    assign wr_clr       = wr_clr_q;
    assign rd_clr       = rd_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_row_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_row_sequencer
// Purpose  : Directed self-checking bench for conv_row_sequencer (default sizes).
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_row_sequencer;

    localparam int IFM_W = 9;
`ifdef CONV_SEQ_WGT_ONCE_EN
    localparam int EXP_WGT = 1;
`else
    localparam int EXP_WGT = 45;
`endif

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ifm_in_valid = 1'b0;
    logic [7:0] ifm_in = 8'd0;
    logic       busy, done, ifm_in_ready, set_ifm, set_wgt, set_reg;
    logic       wr_en_0, wr_en_1, wr_en_2, rd_en_0, rd_en_1, rd_en_2, wr_clr, rd_clr;
    logic [7:0] ifm;
    logic [21:0] outs;

    assign outs = {busy, done, ifm_in_ready, ifm, set_ifm, set_wgt, set_reg,
                   wr_en_0, wr_en_1, wr_en_2, rd_en_0, rd_en_1, rd_en_2, wr_clr, rd_clr};

    conv_row_sequencer dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .ifm_in(ifm_in), .ifm_in_valid(ifm_in_valid), .ifm_in_ready(ifm_in_ready),
        .ifm(ifm), .set_ifm(set_ifm), .set_wgt(set_wgt), .set_reg(set_reg),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .wr_clr(wr_clr), .rd_clr(rd_clr)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int failures = 0;
    int t, n_busy, bidx, n_done, done_t, busy_at_done, seen_done;
    int r0_ifm, r0_wr0, r0_rd, r0_clr;
    int n_ifm, n_wgt, n_reg, n_wr0, n_wr1, n_wr2, n_rd0, n_rd1, n_rd2;
    int n_wrclr, n_rdclr, n_rdclr_c7, n_rd2_row, n_rd2_drain;
    int xfers;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        t = 0; n_busy = 0; bidx = 0; n_done = 0; done_t = -1; busy_at_done = -1; seen_done = 0;
        r0_ifm = 0; r0_wr0 = 0; r0_rd = 0; r0_clr = 0;
        n_ifm = 0; n_wgt = 0; n_reg = 0; n_wr0 = 0; n_wr1 = 0; n_wr2 = 0;
        n_rd0 = 0; n_rd1 = 0; n_rd2 = 0; n_wrclr = 0; n_rdclr = 0; n_rdclr_c7 = 0;
        n_rd2_row = 0; n_rd2_drain = 0;
    endtask

    // Advance one clock and tally what the DUT shows in the new cycle.
    task automatic tick();
        @(posedge clk1);
        #1;
        t++;
        if (busy) begin
            n_busy++;
            bidx++;
            if (bidx <= 10) begin
                r0_ifm += int'(set_ifm);
                r0_wr0 += int'(wr_en_0);
                r0_rd  += int'(rd_en_0) + int'(rd_en_1) + int'(rd_en_2);
                r0_clr += int'(wr_clr) + int'(rd_clr);
            end
        end
        if (done) begin
            n_done++;
            if (seen_done == 0) begin
                done_t = t;
                busy_at_done = int'(busy);
            end
            seen_done = 1;
        end
        n_ifm += int'(set_ifm);  n_wgt += int'(set_wgt);  n_reg += int'(set_reg);
        n_wr0 += int'(wr_en_0);  n_wr1 += int'(wr_en_1);  n_wr2 += int'(wr_en_2);
        n_rd0 += int'(rd_en_0);  n_rd1 += int'(rd_en_1);  n_rd2 += int'(rd_en_2);
        n_wrclr += int'(wr_clr); n_rdclr += int'(rd_clr);
        if (rd_clr && set_ifm && ifm == 8'd8) n_rdclr_c7++;
        if (rd_en_2 && set_ifm) n_rd2_row++;
        if (rd_en_2 && !set_ifm) n_rd2_drain++;
    endtask

    // One job: optional stall after pixel (r=1,c=4), optional start pulse
    // mid-job, optional reset pulse once row 2 is under way.
    task automatic run_job(input int stall_len, input bit mid_start, input bit do_reset);
        int stall_left;
        bit stalled, xfer_now;
        clear_stats();
        xfers = 0;
        ifm_in_valid = 1'b1;
        ifm_in = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        stall_left = stall_len;
        for (int i = 0; i < 300 && seen_done == 0; i++) begin
            if (xfers == IFM_W + 5 && stall_left > 0) begin
                ifm_in_valid = 1'b0;
                stall_left--;
                stalled = 1'b1;
            end else begin
                ifm_in_valid = 1'b1;
                stalled = 1'b0;
            end
            ifm_in = 8'(xfers % IFM_W + 1);
            start = (mid_start && bidx == 20);
            if (do_reset && xfers == 2 * IFM_W + 3) begin
                #2 rst_n = 1'b0;
                #1 check("reset_mid_outputs", int'(outs), 0);
                check("reset_mid_ready", int'(ifm_in_ready), 0);
                @(negedge clk1);
                @(negedge clk1);
                rst_n = 1'b1;
                break;
            end
            xfer_now = ifm_in_valid && ifm_in_ready;
            tick();
            if (xfer_now) xfers++;
            if (stalled) begin
                check("stall_set_ifm", int'(set_ifm), 0);
                check("stall_wr_en_0", int'(wr_en_0), 0);
                check("stall_wr_en_1", int'(wr_en_1), 0);
                check("stall_ifm_hold", int'(ifm), 5);
            end
        end
        start = 1'b0;
        ifm_in_valid = 1'b0;
        if (!do_reset) begin
            check("done_seen", seen_done, 1);
            repeat (3) tick();
        end else begin
            repeat (2) tick();
        end
    endtask

    initial begin
        // Reset held with active inputs.
        rst_n = 1'b0;
        start = 1'b1;
        ifm_in_valid = 1'b1;
        ifm_in = 8'hAA;
        clear_stats();
        repeat (3) tick();
        check("reset_outputs", int'(outs), 0);
        check("reset_ready", int'(ifm_in_ready), 0);
        start = 1'b0;
        ifm_in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_after_reset_busy", n_busy, 0);
        check("idle_after_reset_ready", int'(ifm_in_ready), 0);

        // Unstalled job.
        run_job(0, 1'b0, 1'b0);
        check("job_busy_cycles", n_busy, 60);
        check("job_done_pulses", n_done, 1);
        check("job_done_time", done_t, 62);
        check("job_busy_at_done", busy_at_done, 0);
        check("row0_set_ifm", r0_ifm, 9);
        check("row0_wr_en_0", r0_wr0, 7);
        check("row0_rd_en", r0_rd, 0);
        check("row0_clr", r0_clr, 0);
        check("wr_en_0_total", n_wr0, 21);
        check("wr_en_1_total", n_wr1, 21);
        check("wr_en_2_total", n_wr2, 21);
        check("rd_en_0_total", n_rd0, 21);
        check("rd_en_1_total", n_rd1, 21);
        check("rd_en_2_total", n_rd2, 21);
        check("rd_en_2_rows34", n_rd2_row, 14);
        check("rd_en_2_drain", n_rd2_drain, 7);
        check("wr_clr_total", n_wrclr, 5);
        check("rd_clr_total", n_rdclr, 5);
        check("rd_clr_at_c7", n_rdclr_c7, 4);
        check("set_ifm_total", n_ifm, 45);
        check("set_wgt_total", n_wgt, EXP_WGT);
        check("set_reg_total", n_reg, 60);
        check("ifm_final", int'(ifm), 9);

        // Four-cycle stall at r=1, c=4.
        run_job(4, 1'b0, 1'b0);
        check("stall_done_time", done_t, 66);
        check("stall_busy_cycles", n_busy, 64);
        check("stall_set_ifm_total", n_ifm, 45);
        check("stall_wr_en_0_total", n_wr0, 21);
        check("stall_wr_en_1_total", n_wr1, 21);

        // start pulsed while busy.
        run_job(0, 1'b1, 1'b0);
        check("midstart_done_time", done_t, 62);
        check("midstart_done_pulses", n_done, 1);
        check("midstart_wr_en_2", n_wr2, 21);
        check("midstart_rd_en_0", n_rd0, 21);
        check("midstart_wr_clr", n_wrclr, 5);

        // Reset pulsed in row 2, then a fresh job.
        run_job(0, 1'b0, 1'b1);
        check("post_reset_idle_busy", int'(busy), 0);
        run_job(0, 1'b0, 1'b0);
        check("rerun_busy_cycles", n_busy, 60);
        check("rerun_done_time", done_t, 62);
        check("rerun_row0_set_ifm", r0_ifm, 9);
        check("rerun_wr_en_0", n_wr0, 21);
        check("rerun_rd_clr", n_rdclr, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
